game_flow_ctrl: RTL and testbench

Parametrised game-state controller for the Pac-Man top level. It sequences idle, play, post-death resume, level-clear, game-over and win phases, and detects Pac-Man/ghost collisions across `N_GHOSTS` ghosts. It owns the lives and level counters and drives the reset/enable strobes for the sprite controllers and the map RAM writer. It also feeds the lives/level HEX displays.

---
 rtl/game_pkg.sv | 13 +
 rtl/game_flow_ctrl_phase_timer.sv | 28 ++
 rtl/game_flow_ctrl.sv | 170 +++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the Pac-Man game-flow controller.
package game_pkg;

    typedef enum logic [2:0] {IDLE, PLAY, RESUME, CLEARED, OVER, WON} game_state_t;

    localparam int TILE_X_W = 6;
    localparam int TILE_Y_W = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_phase_timer.sv
// Loadable down-counter used to time the RESUME and CLEARED phases.
module phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         zero
);

    logic [W-1:0] value;

    // Load wins over count; the counter parks at zero rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (count && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-phase sequencer: start/play/resume/clear/over/win, lives and level
// counters, ghost collision detection and sprite/map control strobes.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int N_GHOSTS      = 2,
    parameter int START_LIVES   = 3,
    parameter int MAX_LEVEL     = 3,
    parameter int RESUME_CYCLES = 250_000_000,
    parameter int CLEAR_CYCLES  = 1024,
    parameter int X_W           = TILE_X_W,
    parameter int Y_W           = TILE_Y_W,
    parameter int PILL_W        = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    move_tick,
    input  logic [X_W-1:0]          pac_x,
    input  logic [Y_W-1:0]          pac_y,
    input  logic [N_GHOSTS*X_W-1:0] ghost_x,
    input  logic [N_GHOSTS*Y_W-1:0] ghost_y,
    input  logic [PILL_W-1:0]       pill_remaining,
    output logic [2:0]              state,
    output logic                    sprite_reset,
    output logic                    map_reset,
    output logic                    ghost_enable,
    output logic [2:0]              lives,
    output logic [3:0]              level,
    output logic [N_GHOSTS-1:0]     hit_ghost,
    output logic                    life_lost,
    output logic                    level_up
);

    localparam int TMR_W = $clog2(max_int(RESUME_CYCLES, CLEAR_CYCLES) + 1);
    localparam logic [TMR_W-1:0] RESUME_LOAD = TMR_W'(RESUME_CYCLES - 1);
    localparam logic [TMR_W-1:0] CLEAR_LOAD  = TMR_W'(CLEAR_CYCLES - 1);
    localparam logic [2:0]       LIVES_INIT  = 3'(START_LIVES);
    localparam logic [3:0]       LEVEL_TOP   = 4'(MAX_LEVEL);

    game_state_t         cur, nxt;
    logic                start_q, start_edge;
    logic [N_GHOSTS-1:0] hit_vec, hit_n;
    logic [2:0]          lives_n;
    logic [3:0]          level_n;
    logic                life_lost_n, level_up_n;
    logic                tmr_load, tmr_count, tmr_zero;
    logic [TMR_W-1:0]    tmr_val;

    for (genvar g = 0; g < N_GHOSTS; g++) begin : g_coll
        assign hit_vec[g] = (ghost_x[g*X_W +: X_W] == pac_x) &&
                            (ghost_y[g*Y_W +: Y_W] == pac_y);
    end

    // start_q resets high so a switch already on at reset release is not an edge.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            start_q    <= 1'b1;
            start_edge <= 1'b0;
        end else begin
            start_q    <= start;
            start_edge <= start & ~start_q;
        end
    end

    phase_timer #(.W(TMR_W)) u_timer (
        .clk      (CLOCK_50),
        .rst      (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur       <= IDLE;
            lives     <= LIVES_INIT;
            level     <= 4'd1;
            hit_ghost <= '0;
            life_lost <= 1'b0;
            level_up  <= 1'b0;
        end else begin
            cur       <= nxt;
            lives     <= lives_n;
            level     <= level_n;
            hit_ghost <= hit_n;
            life_lost <= life_lost_n;
            level_up  <= level_up_n;
        end
    end

    always_comb begin
        nxt         = cur;
        lives_n     = lives;
        level_n     = level;
        hit_n       = hit_ghost;
        life_lost_n = 1'b0;
        level_up_n  = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_count   = 1'b0;
        case (cur)
            IDLE: begin
                if (start_edge) nxt = PLAY;
            end
            PLAY: begin
                // A level clear takes priority over a same-cycle collision.
                if (move_tick && (pill_remaining == '0)) begin
                    nxt      = CLEARED;
                    tmr_load = 1'b1;
                    tmr_val  = CLEAR_LOAD;
                end else if (|hit_vec) begin
                    hit_n       = hit_vec;
                    life_lost_n = 1'b1;
                    if (lives <= 3'd1) begin
                        lives_n = 3'd0;
                        nxt     = OVER;
                    end else begin
                        lives_n  = lives - 3'd1;
                        nxt      = RESUME;
                        tmr_load = 1'b1;
                        tmr_val  = RESUME_LOAD;
                    end
                end
            end
            RESUME: begin
                if (tmr_zero) nxt = PLAY;
                else          tmr_count = 1'b1;
            end
            CLEARED: begin
                if (!tmr_zero) begin
                    tmr_count = 1'b1;
                end else if (level >= LEVEL_TOP) begin
                    nxt = WON;
                end else begin
                    level_n    = level + 4'd1;
                    level_up_n = 1'b1;
                    nxt        = PLAY;
                end
            end
            OVER, WON: begin
                if (start_edge) begin
                    nxt     = IDLE;
                    lives_n = LIVES_INIT;
                    level_n = 4'd1;
                    hit_n   = '0;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        sprite_reset = 1'b1;
        map_reset    = 1'b0;
        ghost_enable = 1'b0;
        case (cur)
            IDLE, CLEARED: map_reset = 1'b1;
            PLAY: begin
                sprite_reset = 1'b0;
                ghost_enable = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed plus randomized bench for game_flow_ctrl against a phase-level reference model.
module tb_game_flow_ctrl;
    import game_pkg::*;

    localparam int NG = 3;
    localparam int SL = 3;
    localparam int ML = 2;
    localparam int RC = 4;
    localparam int CC = 3;
    localparam int XW = 6;
    localparam int YW = 5;
    localparam int PW = 8;

    logic clk = 1'b0;
    logic reset, start, move_tick;
    logic [XW-1:0] pac_x;
    logic [YW-1:0] pac_y;
    logic [XW-1:0] gx[NG];
    logic [YW-1:0] gy[NG];
    logic [NG*XW-1:0] ghost_x;
    logic [NG*YW-1:0] ghost_y;
    logic [PW-1:0] pill;
    logic [2:0] state, lives;
    logic [3:0] level;
    logic [NG-1:0] hit_ghost;
    logic sprite_reset, map_reset, ghost_enable, life_lost, level_up;

    assign ghost_x = {gx[2], gx[1], gx[0]};
    assign ghost_y = {gy[2], gy[1], gy[0]};

    game_flow_ctrl #(
        .N_GHOSTS(NG), .START_LIVES(SL), .MAX_LEVEL(ML), .RESUME_CYCLES(RC),
        .CLEAR_CYCLES(CC), .X_W(XW), .Y_W(YW), .PILL_W(PW)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .start(start), .move_tick(move_tick),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .pill_remaining(pill), .state(state), .sprite_reset(sprite_reset),
        .map_reset(map_reset), .ghost_enable(ghost_enable), .lives(lives),
        .level(level), .hit_ghost(hit_ghost), .life_lost(life_lost), .level_up(level_up)
    );

    always #5 clk = ~clk;

    // Reference model: phase, counters and remaining cycles in the timed phases.
    game_state_t   m_state;
    int            m_lives, m_level, m_left;
    logic [NG-1:0] m_hit;
    logic          m_ll, m_lu, m_prev, m_edge;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NG-1:0] coll_vec();
        logic [NG-1:0] v = '0;
        for (int i = 0; i < NG; i++) v[i] = (gx[i] == pac_x) && (gy[i] == pac_y);
        return v;
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_lives = SL; m_level = 1; m_left = 0;
        m_hit = '0; m_ll = 1'b0; m_lu = 1'b0; m_prev = 1'b1; m_edge = 1'b0;
    endtask

    task automatic model_clock();
        logic e;
        logic [NG-1:0] v;
        e = m_edge;
        m_edge = start && !m_prev;
        m_prev = start;
        m_ll = 1'b0;
        m_lu = 1'b0;
        v = coll_vec();
        case (m_state)
            IDLE: if (e) m_state = PLAY;
            PLAY: begin
                if (move_tick && pill == 0) begin
                    m_state = CLEARED; m_left = CC;
                end else if (v != 0) begin
                    m_lives = m_lives - 1; m_hit = v; m_ll = 1'b1;
                    if (m_lives == 0) m_state = OVER;
                    else begin m_state = RESUME; m_left = RC; end
                end
            end
            RESUME: begin
                m_left--;
                if (m_left == 0) m_state = PLAY;
            end
            CLEARED: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_level == ML) m_state = WON;
                    else begin m_level++; m_lu = 1'b1; m_state = PLAY; end
                end
            end
            default: if (e) begin
                m_state = IDLE; m_lives = SL; m_level = 1; m_hit = '0;
            end
        endcase
    endtask

    task automatic check_all();
        logic es, em, eg;
        es = (m_state != PLAY);
        em = (m_state == IDLE) || (m_state == CLEARED);
        eg = (m_state == PLAY);
        check("state", 32'(state), 32'(m_state));
        check("lives", 32'(lives), 32'(m_lives));
        check("level", 32'(level), 32'(m_level));
        check("hit_ghost", 32'(hit_ghost), 32'(m_hit));
        check("life_lost", 32'(life_lost), 32'(m_ll));
        check("level_up", 32'(level_up), 32'(m_lu));
        check("sprite_reset", 32'(sprite_reset), 32'(es));
        check("map_reset", 32'(map_reset), 32'(em));
        check("ghost_enable", 32'(ghost_enable), 32'(eg));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_clock();
        #1;
        check_all();
    endtask

    task automatic ghosts_away();
        for (int i = 0; i < NG; i++) begin
            gx[i] = XW'(i);
            gy[i] = '0;
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; move_tick = 1'b0; pill = 8'd20;
        pac_x = 6'd10; pac_y = 5'd10;
        ghosts_away();
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        step();
        check("rst_idle", 32'(state), 32'(IDLE));

        // start edge -> PLAY two clocks later
        start = 1'b1;
        step();
        check("play_not_yet", 32'(state), 32'(IDLE));
        step();
        check("play_after_start", 32'(state), 32'(PLAY));
        check("ghost_en_play", 32'(ghost_enable), 32'd1);

        // ghost 2 on Pac-Man
        pac_x = 6'd5; pac_y = 5'd7; gx[2] = 6'd5; gy[2] = 5'd7;
        step();
        check("coll1_lives", 32'(lives), 32'd2);
        check("coll1_hit", 32'(hit_ghost), 32'b100);
        check("coll1_pulse", 32'(life_lost), 32'd1);
        gx[2] = 6'd20;
        step();
        check("coll1_pulse_end", 32'(life_lost), 32'd0);
        repeat (2) step();
        check("resume_last", 32'(state), 32'(RESUME));
        step();
        check("resume_done", 32'(state), 32'(PLAY));

        gx[0] = 6'd5; gy[0] = 5'd7;
        step();
        ghosts_away();
        repeat (4) step();
        gx[1] = 6'd5; gy[1] = 5'd7;
        step();
        check("over_state", 32'(state), 32'(OVER));
        check("over_lives", 32'(lives), 32'd0);
        repeat (2) step();
        check("over_no_wrap", 32'(lives), 32'd0);
        ghosts_away();
        start = 1'b0; step();
        start = 1'b1; step(); step();
        check("restart_idle", 32'(state), 32'(IDLE));
        check("restart_lives", 32'(lives), 32'd3);
        check("restart_hit", 32'(hit_ghost), 32'd0);

        // clear beats collision, then second clear wins
        start = 1'b0; step();
        start = 1'b1; step(); step();
        pill = 8'd0; move_tick = 1'b1; gx[0] = 6'd5; gy[0] = 5'd7;
        step();
        check("clear_state", 32'(state), 32'(CLEARED));
        check("clear_lives", 32'(lives), 32'd3);
        pill = 8'd20; move_tick = 1'b0; ghosts_away();
        repeat (2) step();
        step();
        check("lvl2", 32'(level), 32'd2);
        check("lvl_up", 32'(level_up), 32'd1);
        step();
        pill = 8'd0; move_tick = 1'b1;
        step();
        pill = 8'd20; move_tick = 1'b0;
        repeat (3) step();
        check("won_state", 32'(state), 32'(WON));
        check("won_level", 32'(level), 32'd2);

        // double collision
        start = 1'b0; step();
        start = 1'b1; step(); step();
        start = 1'b0; step();
        start = 1'b1; step(); step();
        gx[0] = 6'd5; gy[0] = 5'd7; gx[1] = 6'd5; gy[1] = 5'd7;
        step();
        check("dbl_hit", 32'(hit_ghost), 32'b011);
        check("dbl_lives", 32'(lives), 32'd2);
        ghosts_away();
        step();

        // async reset mid-RESUME, start held through release
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_rst_idle", 32'(state), 32'(IDLE));
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();
        check("held_start_idle", 32'(state), 32'(IDLE));

        // randomized play
        for (int n = 0; n < 600; n++) begin
            move_tick = 1'($urandom_range(0, 1));
            pill = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'd20;
            pac_x = 6'($urandom_range(0, 2));
            pac_y = 5'($urandom_range(0, 1));
            for (int i = 0; i < NG; i++) begin
                gx[i] = 6'($urandom_range(0, 3));
                gy[i] = 5'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 3) == 0) start = ~start;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
